// File: rtl/cs_accum_src_if.sv
// Operand strobe in, redundant VS/VC pair plus completion strobe out.
// "master" is the accumulator: it drives the pair. "slave" is the environment:
// it supplies operands and consumes the pair.
interface cs_accum_src_if #(
    parameter int WIDTH = 16
);
    logic             data_in;
    logic [WIDTH-1:0] A;
    logic             sub;
    logic [WIDTH-1:0] VS;
    logic [WIDTH-1:0] VC;
    logic             data_out;
    logic             busy;

    modport master (
        input  data_in, A, sub,
        output VS, VC, data_out, busy
    );

    modport slave (
        output data_in, A, sub,
        input  VS, VC, data_out, busy
    );
endinterface

// File: rtl/cs_accum_src.sv
// Carry-save accumulator. It sums a burst of NOPS signed operands into a
// redundant (VS, VC) pair without carry propagation, then strobes data_out.
module cs_accum_src #(
    parameter int WIDTH = 16,
    parameter int NOPS  = 4
) (
    input  logic           clk,
    input  logic           reset,
    cs_accum_src_if.master bus
);
    localparam int CNT_W = (NOPS > 1) ? $clog2(NOPS) : 1;

    logic [WIDTH-1:0] vs_q, vs_d;
    logic [WIDTH-1:0] vc_q, vc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dout_q, dout_d;

    logic [WIDTH-1:0] b_term;
    logic [WIDTH-1:0] base_s;
    logic [WIDTH-1:0] base_c;
    logic [WIDTH-1:0] maj;
    logic             last_op;

    // One 3:2 compressor step. A subtract inverts A and injects the +1
    // through the VC LSB, which the carry shift leaves free.
    always_comb begin
        b_term  = bus.sub ? ~bus.A : bus.A;
        base_s  = (cnt_q == '0) ? '0 : vs_q;
        base_c  = (cnt_q == '0) ? '0 : vc_q;
        maj     = (base_s & base_c) | (base_s & b_term) | (base_c & b_term);
        last_op = (cnt_q == CNT_W'(NOPS - 1));

        vs_d   = vs_q;
        vc_d   = vc_q;
        cnt_d  = cnt_q;
        dout_d = 1'b0;
        if (bus.data_in) begin
            vs_d = base_s ^ base_c ^ b_term;
            vc_d = {maj[WIDTH-2:0], bus.sub};
            if (last_op) begin
                cnt_d  = '0;
                dout_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // The pair, the operand counter and the completion strobe. Reset drops
    // any partial burst at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_q   <= '0;
            vc_q   <= '0;
            cnt_q  <= '0;
            dout_q <= 1'b0;
        end else begin
            vs_q   <= vs_d;
            vc_q   <= vc_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    // All outputs come from registers. busy is decoded from the counter.
    always_comb begin
        bus.VS       = vs_q;
        bus.VC       = vc_q;
        bus.data_out = dout_q;
        bus.busy     = (cnt_q != '0);
    end
endmodule
